// File: rtl/route_reservation_arbiter_if.sv
// Route reservation handshake between input ports and the switch allocator.
// The master side drives requests and relieves; the slave (arbiter) returns ownership and crossbar selects.
interface route_reservation_arbiter_if #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
);
  logic [N-1:0]               routeReserveRequestValid;
  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [N-1:0]               routeRelieve;
  logic [N-1:0]               routeReserveStatus;
  logic [N*N-1:0]             outSelect;
  logic [N-1:0]               outBusy;
  logic [N-1:0]               timeoutEvent;

  modport master (
    output routeReserveRequestValid,
    output routeReserveRequest,
    output routeRelieve,
    input  routeReserveStatus,
    input  outSelect,
    input  outBusy,
    input  timeoutEvent
  );

  modport slave (
    input  routeReserveRequestValid,
    input  routeReserveRequest,
    input  routeRelieve,
    output routeReserveStatus,
    output outSelect,
    output outBusy,
    output timeoutEvent
  );
endinterface

// File: rtl/route_reservation_arbiter.sv
// Per-output round-robin allocator holding each output for its owner until relieved.
// Optional watchdog force-free enabled by defining ROUTE_TIMEOUT_EN.
module route_reservation_arbiter #(
  parameter int N              = 4,
  parameter int REQUEST_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  route_reservation_arbiter_if.slave   bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    FREE     = 1'b0,
    RESERVED = 1'b1
  } outState_e;

  outState_e     stateQ [N];
  outState_e     stateD [N];
  logic [PW-1:0] ownerQ [N];
  logic [PW-1:0] ownerD [N];
  logic [PW-1:0] ptrQ   [N];
  logic [PW-1:0] ptrD   [N];
  logic [N-1:0]  ownsAny;
  logic          granted;
  int            cand;

`ifdef ROUTE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cntQ [N];
  logic [CW-1:0] cntD [N];
  logic [N-1:0]  timeoutQ;
  logic [N-1:0]  timeoutD;
`endif

  // An input may hold at most one output; this mask blocks requests from current owners.
  always_comb begin
    ownsAny = '0;
    for (int o = 0; o < N; o++) begin
      if (stateQ[o] == RESERVED) begin
        ownsAny[ownerQ[o]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < N; o++) begin
        stateQ[o] <= FREE;
        ownerQ[o] <= '0;
        ptrQ[o]   <= '0;
`ifdef ROUTE_TIMEOUT_EN
        cntQ[o]   <= '0;
`endif
      end
`ifdef ROUTE_TIMEOUT_EN
      timeoutQ <= '0;
`endif
    end else begin
      for (int o = 0; o < N; o++) begin
        stateQ[o] <= stateD[o];
        ownerQ[o] <= ownerD[o];
        ptrQ[o]   <= ptrD[o];
`ifdef ROUTE_TIMEOUT_EN
        cntQ[o]   <= cntD[o];
`endif
      end
`ifdef ROUTE_TIMEOUT_EN
      timeoutQ <= timeoutD;
`endif
    end
  end

  // Arbitration sees only registered ownership, so a freed output is regranted one edge later.
  always_comb begin
    granted = 1'b0;
    cand    = 0;
`ifdef ROUTE_TIMEOUT_EN
    timeoutD = '0;
`endif
    for (int o = 0; o < N; o++) begin
      stateD[o] = stateQ[o];
      ownerD[o] = ownerQ[o];
      ptrD[o]   = ptrQ[o];
`ifdef ROUTE_TIMEOUT_EN
      cntD[o]   = cntQ[o];
`endif
      if (stateQ[o] == RESERVED) begin
        if (bus.routeRelieve[ownerQ[o]]) begin
          stateD[o] = FREE;
`ifdef ROUTE_TIMEOUT_EN
        end else if (cntQ[o] == CW'(TIMEOUT_CYCLES - 1)) begin
          stateD[o]   = FREE;
          timeoutD[o] = 1'b1;
        end else begin
          cntD[o] = cntQ[o] + 1'b1;
`endif
        end
      end else begin
        granted = 1'b0;
        for (int k = 0; k < N; k++) begin
          cand = int'(ptrQ[o]) + k;
          if (cand >= N) begin
            cand = cand - N;
          end
          if (!granted && bus.routeReserveRequestValid[cand] && !ownsAny[cand] &&
              int'(bus.routeReserveRequest[cand*REQUEST_WIDTH +: REQUEST_WIDTH]) == o) begin
            granted   = 1'b1;
            stateD[o] = RESERVED;
            ownerD[o] = PW'(cand);
            ptrD[o]   = (cand == N - 1) ? '0 : PW'(cand + 1);
`ifdef ROUTE_TIMEOUT_EN
            cntD[o]   = '0;
`endif
          end
        end
      end
    end
  end

  always_comb begin
    bus.outBusy            = '0;
    bus.outSelect          = '0;
    bus.routeReserveStatus = ownsAny;
    for (int o = 0; o < N; o++) begin
      if (stateQ[o] == RESERVED) begin
        bus.outBusy[o]                         = 1'b1;
        bus.outSelect[o*N + int'(ownerQ[o])]   = 1'b1;
      end
    end
`ifdef ROUTE_TIMEOUT_EN
    bus.timeoutEvent = timeoutQ;
`else
    bus.timeoutEvent = '0;
`endif
  end

endmodule
